// File: rtl/strobe_period_meter_pkg.sv
// Shared types and reset constants for strobe_period_meter and its saturating counter.
package strobe_period_meter_pkg;

  typedef enum logic [1:0] {
    ST_IDLE      = 2'd0,
    ST_ARMED     = 2'd1,
    ST_MEASURING = 2'd2
  } meter_state_e;

  // Replicated to the period width: min starts at all-ones, max at zero.
  localparam logic MIN_RST_BIT = 1'b1;
  localparam logic MAX_RST_BIT = 1'b0;

endpackage

// File: rtl/strobe_period_meter_sat_counter.sv
// Saturating up-counter with synchronous clear (priority) and enable; holds at all-ones.
module strobe_period_meter_sat_counter #(
  parameter int WIDTH = 16
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             clear,
  input  logic             en,
  output logic [WIDTH-1:0] count
);

  function automatic logic [WIDTH-1:0] sat_inc(input logic [WIDTH-1:0] v);
    return (&v) ? v : v + WIDTH'(1);
  endfunction

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (en) begin
      count <= sat_inc(count);
    end
  end

endmodule

// File: rtl/strobe_period_meter.sv
// Measures last/min/max strobe interval (as period-1) and a saturating interval count.
// Optional min/max tracking is built only when STROBE_PERIOD_METER_MINMAX_EN is defined.
module strobe_period_meter
  import strobe_period_meter_pkg::*;
#(
  parameter int CTRL_PERIOD_W = 16,
  parameter int CTRL_COUNT_W  = 16
) (
  input  logic                     i_clk,
  input  logic                     i_rst,
  input  logic                     i_cg,
  input  logic                     i_clear,
  input  logic                     i_strobe,
  output logic [CTRL_PERIOD_W-1:0] o_lastPeriodM1,
  output logic [CTRL_PERIOD_W-1:0] o_minPeriodM1,
  output logic [CTRL_PERIOD_W-1:0] o_maxPeriodM1,
  output logic [CTRL_COUNT_W-1:0]  o_nIntervals,
  output logic                     o_valid,
  output logic                     o_overflow
);

  meter_state_e state, state_nxt;
  logic [CTRL_PERIOD_W-1:0] ivl_cnt;
  logic capture, ivl_clear, ivl_en, stat_clear;

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) state <= ST_IDLE;
    else        state <= state_nxt;
  end

  // Clear beats a coincident strobe; with the gate low nothing moves.
  always_comb begin
    state_nxt  = state;
    capture    = 1'b0;
    ivl_clear  = 1'b0;
    ivl_en     = 1'b0;
    stat_clear = i_cg & i_clear;
    if (i_cg) begin
      if (i_clear) begin
        state_nxt = ST_IDLE;
        ivl_clear = 1'b1;
      end else begin
        case (state)
          ST_IDLE: begin
            ivl_clear = 1'b1;
            if (i_strobe) state_nxt = ST_ARMED;
          end
          ST_ARMED, ST_MEASURING: begin
            if (i_strobe) begin
              capture   = 1'b1;
              ivl_clear = 1'b1;
              state_nxt = ST_MEASURING;
            end else begin
              ivl_en = 1'b1;
            end
          end
          default: begin
            state_nxt = ST_IDLE;
            ivl_clear = 1'b1;
          end
        endcase
      end
    end
  end

  strobe_period_meter_sat_counter #(.WIDTH(CTRL_PERIOD_W)) u_ivl_cnt (
    .clk   (i_clk),
    .rst_n (i_rst),
    .clear (ivl_clear),
    .en    (ivl_en),
    .count (ivl_cnt)
  );

  strobe_period_meter_sat_counter #(.WIDTH(CTRL_COUNT_W)) u_n_cnt (
    .clk   (i_clk),
    .rst_n (i_rst),
    .clear (stat_clear),
    .en    (capture),
    .count (o_nIntervals)
  );

  // A saturated counter at capture means the true interval did not fit.
  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      o_lastPeriodM1 <= '0;
      o_valid        <= 1'b0;
      o_overflow     <= 1'b0;
    end else if (stat_clear) begin
      o_lastPeriodM1 <= '0;
      o_valid        <= 1'b0;
      o_overflow     <= 1'b0;
    end else if (capture) begin
      o_lastPeriodM1 <= ivl_cnt;
      o_valid        <= 1'b1;
      if (&ivl_cnt) o_overflow <= 1'b1;
    end
  end

`ifdef STROBE_PERIOD_METER_MINMAX_EN
  localparam logic [CTRL_PERIOD_W-1:0] MIN_RST = {CTRL_PERIOD_W{MIN_RST_BIT}};
  localparam logic [CTRL_PERIOD_W-1:0] MAX_RST = {CTRL_PERIOD_W{MAX_RST_BIT}};

  always_ff @(posedge i_clk or negedge i_rst) begin
    if (!i_rst) begin
      o_minPeriodM1 <= MIN_RST;
      o_maxPeriodM1 <= MAX_RST;
    end else if (stat_clear) begin
      o_minPeriodM1 <= MIN_RST;
      o_maxPeriodM1 <= MAX_RST;
    end else if (capture) begin
      if (ivl_cnt < o_minPeriodM1) o_minPeriodM1 <= ivl_cnt;
      if (ivl_cnt > o_maxPeriodM1) o_maxPeriodM1 <= ivl_cnt;
    end
  end
`else
  assign o_minPeriodM1 = '0;
  assign o_maxPeriodM1 = {CTRL_PERIOD_W{MAX_RST_BIT}};
`endif

endmodule
